// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Contents:
//   arb_state_e    - two-state arbiter FSM encoding (arbitrate / granted).
//   clog2_ladder() - ceiling log2. The FIFO pointer width uses the same ladder.
//   id_width()     - producer index width, at least 1 bit.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    StArb   = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2_ladder(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (clog2_ladder(n) < 1) ? 1 : clog2_ladder(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i       - request vector, one bit per producer
//   last_i      - index of the most recent winner
//   pick_o      - first requesting index after last_i, wrapping modulo NUM_REQ
//   any_valid_o - high when at least one request is set
module rr_pick #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] last_i,
  output logic [ID_WIDTH-1:0] pick_o,
  output logic                any_valid_o
);

  always_comb begin
    int idx;
    pick_o      = '0;
    any_valid_o = 1'b0;
    idx         = 0;
    // Offset 1 is checked first, so last_i itself is checked last.
    // This gives a strict rotation.
    for (int off = 1; off <= int'(NUM_REQ); off++) begin
      idx = (int'(last_i) + off) % int'(NUM_REQ);
      if (!any_valid_o && req_i[idx]) begin
        pick_o      = ID_WIDTH'(idx);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ valid/ready producers.
// Arbitration is round-robin. Each grant lasts at most MAX_BURST beats.
// Ports:
//   clk, rst_n    - clock; synchronous active-low reset
//   req_valid     - per-producer beat valid
//   req_data      - producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     - per-producer accept; only the owner can be ready
//   fifo_full     - FIFO full flag; stalls the owner
//   fifo_w_en     - FIFO write enable
//   fifo_data_in  - FIFO write data (owner's slice, else 0)
//   grant_valid   - a producer owns the port
//   grant_id      - index of the current or most recent owner
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id
);

  localparam int unsigned CntWidth = clog2_ladder(MAX_BURST) + 1;

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [CntWidth-1:0] count_q, count_d, count_inc;
  logic [ID_WIDTH-1:0] pick;
  logic                any_valid;
  logic                owner_valid;
  logic                granted;
  logic                xfer;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req_i       (req_valid),
    .last_i      (last_q),
    .pick_o      (pick),
    .any_valid_o (any_valid)
  );

  // Outputs are gated by rst_n so nothing is written during a reset cycle.
  // This holds even if the FSM is still in GRANT at that point.
  assign granted     = rst_n && (state_q == StGrant);
  assign owner_valid = req_valid[grant_id_q];
  assign xfer        = granted && owner_valid && !fifo_full;
  assign count_inc   = count_q + CntWidth'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StArb;
      grant_id_q <= '0;
      // Start the pointer at the last index, so producer 0 scans first.
      last_q     <= ID_WIDTH'(NUM_REQ - 1);
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      count_q    <= count_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    count_d    = count_q;
    case (state_q)
      StArb: begin
        if (any_valid) begin
          grant_id_d = pick;
          last_d     = pick;
          count_d    = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (xfer) count_d = count_inc;
        // An idle owner releases the grant even while the FIFO is full.
        if (!owner_valid || (xfer && (count_inc == CntWidth'(MAX_BURST)))) begin
          state_d = StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    grant_valid  = 1'b0;
    grant_id     = grant_id_q;
    if (granted) begin
      grant_valid           = 1'b1;
      req_ready[grant_id_q] = !fifo_full;
      fifo_w_en             = xfer;
      fifo_data_in          = req_data[int'(grant_id_q) * int'(DATA_WIDTH) +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_data_in;
  logic              grant_valid;
  logic [IW-1:0]     grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic        full;
    logic [31:0] data;
    logic        w_en;
    logic [7:0]  din;
    logic [3:0]  ready;
    logic        gv;
    logic [1:0]  gid;
    logic        chk_gid;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic f, input logic [31:0] d);
    rst_n     = r;
    req_valid = v;
    fifo_full = f;
    req_data  = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic [3:0] v, input logic f,
                              input logic [31:0] d, input logic we, input logic [7:0] din,
                              input logic [3:0] rdy, input logic gv, input logic [1:0] gid,
                              input logic cg);
    vec_t t;
    t.rst_n = r;  t.valid = v;  t.full = f;  t.data = d;
    t.w_en = we;  t.din = din;  t.ready = rdy;  t.gv = gv;  t.gid = gid;  t.chk_gid = cg;
    vecs.push_back(t);
  endfunction

  localparam logic [31:0] DAll = 32'hD3D2_D1D0;
  localparam logic [31:0] DP01 = 32'h0000_2010;

  int          writes;
  int          seq [4];
  int          exp_seq [4];
  int          got;
  int          run;
  logic [7:0]  q[$];
  logic [7:0]  item;
  logic        do_pop;
  logic [1:0]  pid;

  initial begin
    // Reset with every producer requesting, then producer 0 wins first.
    add(0, 4'hF, 0, DAll, 0, 8'h00, 4'b0000, 0, 0, 0);
    add(0, 4'hF, 0, DAll, 0, 8'h00, 4'b0000, 0, 0, 1);
    add(0, 4'hF, 0, DAll, 0, 8'h00, 4'b0000, 0, 0, 1);
    add(1, 4'hF, 0, DAll, 0, 8'h00, 4'b0000, 0, 0, 1);
    add(1, 4'hF, 0, DAll, 1, 8'hD0, 4'b0001, 1, 0, 1);
    add(1, 4'h0, 0, DAll, 0, 8'hD0, 4'b0001, 1, 0, 1);
    add(1, 4'h0, 0, DAll, 0, 8'h00, 4'b0000, 0, 0, 1);
    // Single producer P2: three beats, then valid drops.
    add(1, 4'b0100, 0, 32'h00A1_0000, 0, 8'h00, 4'b0000, 0, 0, 1);
    add(1, 4'b0100, 0, 32'h00A1_0000, 1, 8'hA1, 4'b0100, 1, 2, 1);
    add(1, 4'b0100, 0, 32'h00A2_0000, 1, 8'hA2, 4'b0100, 1, 2, 1);
    add(1, 4'b0100, 0, 32'h00A3_0000, 1, 8'hA3, 4'b0100, 1, 2, 1);
    add(1, 4'b0000, 0, 32'h00A3_0000, 0, 8'hA3, 4'b0100, 1, 2, 1);
    add(1, 4'b0000, 0, 32'h0000_0000, 0, 8'h00, 4'b0000, 0, 2, 1);
    // P0 and P1 always valid: P0 x4, idle, P1 x4, idle, P0 x4.
    for (int r = 0; r < 3; r++) begin
      logic [1:0] own;
      logic [1:0] prev;
      own  = (r == 1) ? 2'd1 : 2'd0;
      prev = (r == 0) ? 2'd2 : ((r == 1) ? 2'd0 : 2'd1);
      add(1, 4'b0011, 0, DP01, 0, 8'h00, 4'b0000, 0, prev, 1);
      for (int b = 0; b < 4; b++)
        add(1, 4'b0011, 0, DP01, 1, (own == 2'd1) ? 8'h20 : 8'h10,
            (own == 2'd1) ? 4'b0010 : 4'b0001, 1, own, 1);
    end
    add(1, 4'b0000, 0, DP01, 0, 8'h00, 4'b0000, 0, 0, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      v = vecs[k];
      drive(v.rst_n, v.valid, v.full, v.data);
      #1;
      chk($sformatf("vec%0d_w_en", k), 32'(fifo_w_en), 32'(v.w_en));
      chk($sformatf("vec%0d_data", k), 32'(fifo_data_in), 32'(v.din));
      chk($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(v.ready));
      chk($sformatf("vec%0d_gv", k), 32'(grant_valid), 32'(v.gv));
      if (v.chk_gid) chk($sformatf("vec%0d_gid", k), 32'(grant_id), 32'(v.gid));
      tick();
    end

    // Full stall: P3 owns the port, and the FIFO is full for 5 cycles mid-burst.
    writes = 0;
    drive(1, 4'b1000, 0, 32'h3100_0000);
    #1; chk("stall_arb_gv", 32'(grant_valid), 32'd0);
    tick();
    for (int b = 1; b <= 4; b++) begin
      if (b == 3) begin
        for (int s = 0; s < 5; s++) begin
          drive(1, 4'b1000, 1, 32'h3300_0000);
          #1;
          chk("stall_w_en", 32'(fifo_w_en), 32'd0);
          chk("stall_ready", 32'(req_ready), 32'd0);
          chk("stall_gid", {31'd0, grant_valid} + 32'(grant_id), 32'd4);
          tick();
        end
      end
      drive(1, 4'b1000, 0, {8'h30 + 8'(b), 24'h0});
      #1;
      if (fifo_w_en) writes++;
      chk("stall_beat_data", 32'(fifo_data_in), 32'(8'h30 + 8'(b)));
      tick();
    end
    drive(1, 4'b0000, 0, 32'h0);
    #1;
    chk("stall_total", 32'(writes), 32'd4);
    chk("stall_cap_release", 32'(grant_valid), 32'd0);
    tick();

    // Reset mid-burst: P1 writes 2 of 4 beats, then reset.
    drive(1, 4'b0010, 0, 32'h0000_5100);
    tick();
    for (int b = 0; b < 2; b++) begin
      drive(1, 4'b0010, 0, 32'h0000_5100);
      #1; chk("rstmid_beat", 32'(fifo_w_en), 32'd1);
      tick();
    end
    drive(0, 4'b0011, 0, 32'h0000_5150);
    #1;
    chk("rstmid_no_write", 32'(fifo_w_en), 32'd0);
    chk("rstmid_no_ready", 32'(req_ready), 32'd0);
    tick();
    drive(1, 4'b0011, 0, 32'h0000_5150);
    #1;
    chk("rstmid_arb", 32'(grant_valid), 32'd0);
    chk("rstmid_gid0", 32'(grant_id), 32'd0);
    tick();
    #0;
    chk("rstmid_p0_first", {31'd0, grant_valid} + 32'(grant_id), 32'd1);
    chk("rstmid_p0_data", 32'(fifo_data_in), 32'h50);
    drive(1, 4'b0000, 0, 32'h0);
    tick();
    tick();

    // End to end: DEPTH-8 FIFO model, 4 producers x 16 tagged beats, random reads.
    for (int i = 0; i < 4; i++) begin seq[i] = 0; exp_seq[i] = 0; end
    got = 0;
    run = 0;
    for (int cyc = 0; cyc < 3000 && got < 64; cyc++) begin
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        req_valid[i]       = (seq[i] < 16);
        req_data[i*8 +: 8] = {2'(i), 2'b00, 4'(seq[i])};
      end
      fifo_full = (q.size() == 8);
      #1;
      do_pop = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      if (fifo_full) chk("e2e_no_write_full", 32'(fifo_w_en), 32'd0);
      if (!grant_valid) run = 0;
      if (fifo_w_en) begin
        run++;
        if (run > 4) chk("e2e_burst_cap", 32'(run), 32'd4);
      end
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) seq[i]++;
      if (do_pop) begin
        item = q.pop_front();
        pid  = item[7:6];
        chk("e2e_order", 32'(item), {24'd0, pid, 2'b00, 4'(exp_seq[pid])});
        exp_seq[pid]++;
        got++;
      end
      if (fifo_w_en) q.push_back(fifo_data_in);
      tick();
    end
    chk("e2e_count", 32'(got), 32'd64);
    for (int i = 0; i < 4; i++) chk($sformatf("e2e_p%0d_total", i), 32'(exp_seq[i]), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
